i2c_rd_byte_uart_reporter: RTL and testbench
============================================

Name: i2c_rd_byte_uart_reporter

Overview:
- Downstream consumer of the periodic I2C register-read master. Observes the master's `sda_dir` and `data_out` on the same 200 kHz clock.
- Detects each completed read byte and captures it.
- Transmits the byte over a UART TX line as two uppercase hex ASCII characters followed by CR LF, for bench/PC monitoring.
- Holds a one-deep overwrite buffer so that reads arriving faster than the UART can drain them are counted, not queued.

Parameters:
- BAUD_DIV, 21, clk_200khz cycles per UART bit (21 gives ≈9524 baud).
- MIN_LOW, 100, minimum consecutive `sda_dir`=0 cycles that qualify a low interval as a read-data phase. ACK phases are 20 cycles; the data phase is 160.

Ports:
- clk_200khz  input  1  system clock, 200 kHz
- rst  input  1  reset, asynchronous, active-high
- data_in  input  8  `data_out` of the I2C read master
- sda_dir  input  1  `sda_dir` of the I2C read master; 1 = master driving, 0 = slave driving
- tx  output  1  UART TX, 8N1, idle high
- busy  output  1  1 while a report frame is being transmitted
- sample  output  8  last captured byte
- new_sample  output  1  one-cycle pulse on each capture
- dropped_cnt  output  8  count of captured samples overwritten before transmission; saturates at 255

Behaviour:
- Reset values (async): tx=1, busy=0, sample=0, new_sample=0, dropped_cnt=0; low_cnt=0, sda_dir_q=1, pend_valid=0; FSM state IDLE.
- Detection:
  - sda_dir_q = sda_dir registered.
  - low_cnt (9 bit) increments while sda_dir=0, saturating at 511; it clears on the edge after sda_dir=1.
  - Capture event: sda_dir=1 && sda_dir_q=0 && low_cnt>=MIN_LOW.
  - On that edge: sample<=data_in, new_sample<=1 (0 on all other edges), pend_data<=data_in, pend_valid<=1.
  - If pend_valid was already 1 and is not being consumed on the same edge, dropped_cnt increments (saturating) and pend_data is overwritten.
- Low intervals shorter than MIN_LOW produce no capture.
- Consumption: in IDLE with pend_valid=1, the FSM clears pend_valid, latches pend_data into frame_data, and enters START.
  - If a capture event occurs on that same edge, pend_valid stays 1 with the new data.
  - That case is not a drop.
- Latency: tx falls exactly 2 clk edges after the capture edge when the FSM was idle.
- Character sequence, char_idx 0..3:
  - 0: hex(frame_data[7:4])
  - 1: hex(frame_data[3:0])
  - 2: 0x0D
  - 3: 0x0A
  - Hex mapping: 0-9 → 0x30-0x39, A-F → 0x41-0x46.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx=0 for BAUD_DIV cycles → DATA.
  - DATA: 8 bits LSB first, each BAUD_DIV cycles, bit_idx 0..7 → STOP.
  - STOP: tx=1 for BAUD_DIV cycles. Then, if char_idx<3: char_idx++, → START. Otherwise → IDLE.
  - There is no idle gap between characters.
  - The full frame is 40×BAUD_DIV = 840 cycles.
- busy=1 in START/DATA/STOP, 0 in IDLE.
- Baud counter: 0..BAUD_DIV-1, reset at each state or bit change.
- Reset mid-frame: tx returns to 1 immediately (async), the frame is abandoned, and pending data is discarded.
- Captures continue while busy; only one pending sample is held.

Optional Feature:
- REPORT_ON_CHANGE_EN
  - Defined: a pending sample equal to the last transmitted byte is discarded in IDLE (pend_valid cleared, no frame). last_tx resets to 0x00, so a first value of 0x00 is never sent. Discards do not increment dropped_cnt.
  - Undefined: every consumed sample is transmitted.

Test Plan:
- Reset → tx=1, busy=0, sample=0x00, dropped_cnt=0, new_sample=0 for 1000 cycles with sda_dir=1.
- Drive data_in=0x3C, sda_dir low for 160 cycles then high → new_sample pulse 1 cycle, sample=0x3C; tx falls 2 cycles later; bytes 0x33, 0x43, 0x0D, 0x0A, each bit 21 cycles; busy low after 840 cycles.
- sda_dir low for 20 cycles then high (ACK shape) → no new_sample, tx stays 1.
- Three qualifying events 300 cycles apart with values 0x11, 0x22, 0x33:
  - Frame 1 carries 0x11.
  - dropped_cnt=1 after the third event.
  - Frame 2 carries 0x33.
  - 0x22 is never sent.
- Assert rst during DATA of char 1 → tx=1 within the same cycle, busy=0, no further frames without new events.
- With REPORT_ON_CHANGE_EN: two events, both 0x5A → one frame only; a third event of 0xA5 → second frame sent.

Source files
------------

// File: rtl/i2c_rd_byte_uart_reporter.sv
// Purpose : captures each completed I2C read byte (a long sda_dir-low data phase followed by
//           sda_dir returning high) and reports it on a UART TX line as "HH\r\n" (8N1).
// Latency : tx falls 2 clk_200khz edges after the capture edge when idle. A frame lasts 40*BAUD_DIV cycles.
// Backpressure: none upstream. A one-deep pending slot is overwritten by newer captures, and each overwrite
//           counts in dropped_cnt (saturating).
// Ports   : clk_200khz/rst (async, active-high); data_in/sda_dir from the I2C read master;
//           tx (UART, idle high), busy, sample, new_sample (1-cycle pulse), dropped_cnt.
// Option  : `define REPORT_ON_CHANGE_EN drops pending samples that equal the last transmitted byte.
module i2c_rd_byte_uart_reporter #(
    parameter int BAUD_DIV = 21,
    parameter int MIN_LOW  = 100
) (
    input  logic       clk_200khz,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       sda_dir,
    output logic       tx,
    output logic       busy,
    output logic [7:0] sample,
    output logic       new_sample,
    output logic [7:0] dropped_cnt
);

    localparam int BW = $clog2(BAUD_DIV + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [1:0]    r_char_idx;
    logic [7:0]    r_frame_data;
    logic          r_tx;
    logic          r_busy;

    logic          r_sda_dir_q;
    logic [8:0]    r_low_cnt;
    logic [7:0]    r_sample;
    logic          r_new_sample;
    logic [7:0]    r_dropped_cnt;
    logic [7:0]    r_pend_data;
    logic          r_pend_valid;

    logic          w_cap;
    logic          w_consume;
    logic          w_send;
    logic          w_baud_end;
    logic [7:0]    w_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Rising sda_dir after a long slave-driven interval marks the end of a read data phase;
    // short ACK intervals never reach MIN_LOW.
    assign w_cap      = sda_dir && !r_sda_dir_q && (r_low_cnt >= 9'(MIN_LOW));
    // In IDLE the pending slot is always emptied, either into a frame or discarded.
    assign w_consume  = (r_state == S_IDLE) && r_pend_valid;
    assign w_baud_end = (r_baud == BW'(BAUD_DIV - 1));

`ifdef REPORT_ON_CHANGE_EN
    logic [7:0] r_last_tx;
    assign w_send = r_pend_valid && (r_pend_data != r_last_tx);
`else
    assign w_send = r_pend_valid;
`endif

    always_comb begin
        w_char = 8'h0A;
        case (r_char_idx)
            2'd0:    w_char = hex_ascii(r_frame_data[7:4]);
            2'd1:    w_char = hex_ascii(r_frame_data[3:0]);
            2'd2:    w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    // Detection and the one-deep pending slot
    always_ff @(posedge clk_200khz or posedge rst) begin
        if (rst) begin
            r_sda_dir_q   <= 1'b1;
            r_low_cnt     <= 9'd0;
            r_sample      <= 8'h00;
            r_new_sample  <= 1'b0;
            r_dropped_cnt <= 8'h00;
            r_pend_data   <= 8'h00;
            r_pend_valid  <= 1'b0;
        end else begin
            r_sda_dir_q  <= sda_dir;
            r_new_sample <= w_cap;
            if (!sda_dir) begin
                if (r_low_cnt != 9'd511) r_low_cnt <= r_low_cnt + 9'd1;
            end else begin
                r_low_cnt <= 9'd0;
            end
            if (w_cap) begin
                r_sample     <= data_in;
                r_pend_data  <= data_in;
                r_pend_valid <= 1'b1;
                // Overwriting an unconsumed sample is a drop; replacing one the FSM takes this edge is not.
                if (r_pend_valid && !w_consume && (r_dropped_cnt != 8'hFF))
                    r_dropped_cnt <= r_dropped_cnt + 8'd1;
            end else if (w_consume) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // UART frame FSM. tx/busy are registered from the current state, so they lag the state by one edge.
    always_ff @(posedge clk_200khz or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= 3'd0;
            r_char_idx   <= 2'd0;
            r_frame_data <= 8'h00;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
`ifdef REPORT_ON_CHANGE_EN
            r_last_tx    <= 8'h00;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_send) begin
                        r_frame_data <= r_pend_data;
                        r_char_idx   <= 2'd0;
                        r_baud       <= '0;
                        r_state      <= S_START;
`ifdef REPORT_ON_CHANGE_EN
                        r_last_tx    <= r_pend_data;
`endif
                    end
                end
                S_START: begin
                    r_tx   <= 1'b0;
                    r_busy <= 1'b1;
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    r_tx   <= w_char[r_bit_idx];
                    r_busy <= 1'b1;
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                        else                   r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b1;
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_char_idx == 2'd3) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_char_idx <= r_char_idx + 2'd1;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign sample      = r_sample;
    assign new_sample  = r_new_sample;
    assign dropped_cnt = r_dropped_cnt;

endmodule

// File: tb/tb_i2c_rd_byte_uart_reporter.sv
module tb_i2c_rd_byte_uart_reporter;

    logic       clk_200khz = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       sda_dir;
    logic       tx;
    logic       busy;
    logic [7:0] sample;
    logic       new_sample;
    logic [7:0] dropped_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    i2c_rd_byte_uart_reporter #(.BAUD_DIV(21), .MIN_LOW(100)) dut (
        .clk_200khz (clk_200khz),
        .rst        (rst),
        .data_in    (data_in),
        .sda_dir    (sda_dir),
        .tx         (tx),
        .busy       (busy),
        .sample     (sample),
        .new_sample (new_sample),
        .dropped_cnt(dropped_cnt)
    );

    always #5 clk_200khz = ~clk_200khz;
    always @(posedge clk_200khz) cyc <= cyc + 1;

    // One read-phase shape: sda_dir low for 'low' edges, then high; returns at the negedge after the rising edge.
    task automatic do_event(input logic [7:0] d, input int low);
        @(negedge clk_200khz);
        data_in = d;
        sda_dir = 1'b0;
        repeat (low) @(negedge clk_200khz);
        sda_dir = 1'b1;
        @(negedge clk_200khz);
    endtask

    // Receive one 8N1 character, sampling mid-bit on negedges.
    task automatic recv_char(input string name, output logic [7:0] c, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        c  = 8'h00;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk_200khz);
            n++;
        end
        total++;
        if (tx !== 1'b0) begin
            bad++;
            ok = 1'b0;
            $display("FAIL %s start-bit timeout: tx=%b required 0", name, tx);
        end else begin
            repeat (10) @(negedge clk_200khz);
            total++;
            if (tx !== 1'b0) begin
                bad++;
                ok = 1'b0;
                $display("FAIL %s start bit width: tx=%b required 0", name, tx);
            end
            for (int b = 0; b < 8; b++) begin
                repeat (21) @(negedge clk_200khz);
                c[b] = tx;
            end
            repeat (21) @(negedge clk_200khz);
            total++;
            if (tx !== 1'b1) begin
                bad++;
                ok = 1'b0;
                $display("FAIL %s stop bit: tx=%b required 1", name, tx);
            end
        end
    endtask

    task automatic recv_frame(input string name, input logic [7:0] h, input logic [7:0] l);
        logic [7:0] exp_c [4];
        logic [7:0] c;
        bit         ok;
        exp_c[0] = h;
        exp_c[1] = l;
        exp_c[2] = 8'h0D;
        exp_c[3] = 8'h0A;
        for (int i = 0; i < 4; i++) begin
            recv_char(name, c, ok);
            total++;
            if (c !== exp_c[i]) begin
                bad++;
                $display("FAIL %s char%0d: got 0x%02h required 0x%02h", name, i, c, exp_c[i]);
            end
        end
    endtask

    // tx must stay high for n cycles
    task automatic expect_quiet(input string name, input int n);
        int lows;
        lows = 0;
        repeat (n) begin
            @(negedge clk_200khz);
            if (tx !== 1'b1 || new_sample !== 1'b0) lows++;
        end
        total++;
        if (lows != 0) begin
            bad++;
            $display("FAIL %s: %0d cycles with tx low or new_sample set, required 0", name, lows);
        end
    endtask

    task automatic test_reset;
        int errs;
        rst = 1'b1;
        sda_dir = 1'b1;
        data_in = 8'h00;
        repeat (3) @(negedge clk_200khz);
        rst = 1'b0;
        @(negedge clk_200khz);
        total++; if (tx !== 1'b1)           begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++; if (sample !== 8'h00)      begin bad++; $display("FAIL reset_sample: got 0x%02h required 0x00", sample); end
        total++; if (new_sample !== 1'b0)   begin bad++; $display("FAIL reset_new_sample: got %b required 0", new_sample); end
        total++; if (dropped_cnt !== 8'h00) begin bad++; $display("FAIL reset_dropped: got %0d required 0", dropped_cnt); end
        errs = 0;
        repeat (1000) begin
            @(negedge clk_200khz);
            if (tx !== 1'b1 || busy !== 1'b0 || sample !== 8'h00 || new_sample !== 1'b0 || dropped_cnt !== 8'h00) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL reset_hold: %0d bad cycles, required 0", errs); end
    endtask

    task automatic test_frame;
        int t0;
        int n;
        do_event(8'h3C, 160);
        total++; if (new_sample !== 1'b1) begin bad++; $display("FAIL frame_pulse: got %b required 1", new_sample); end
        total++; if (sample !== 8'h3C)    begin bad++; $display("FAIL frame_sample: got 0x%02h required 0x3C", sample); end
        total++; if (tx !== 1'b1)         begin bad++; $display("FAIL frame_lat0: tx=%b required 1", tx); end
        @(negedge clk_200khz);
        total++; if (new_sample !== 1'b0) begin bad++; $display("FAIL frame_pulse_width: got %b required 0", new_sample); end
        total++; if (tx !== 1'b1)         begin bad++; $display("FAIL frame_lat1: tx=%b required 1", tx); end
        @(negedge clk_200khz);
        total++; if (tx !== 1'b0)         begin bad++; $display("FAIL frame_lat2: tx=%b required 0", tx); end
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL frame_busy: got %b required 1", busy); end
        t0 = cyc;
        recv_frame("frame_3C", 8'h33, 8'h43);
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk_200khz);
            n++;
        end
        total++;
        if (cyc - t0 != 840) begin bad++; $display("FAIL frame_length: busy for %0d cycles required 840", cyc - t0); end
    endtask

    task automatic test_ack_shape;
        do_event(8'hA7, 20);
        total++; if (new_sample !== 1'b0) begin bad++; $display("FAIL ack_pulse: got %b required 0", new_sample); end
        total++; if (sample !== 8'h3C)    begin bad++; $display("FAIL ack_sample: got 0x%02h required 0x3C", sample); end
        expect_quiet("ack_quiet", 100);
    endtask

    task automatic test_overwrite;
        fork
            begin
                do_event(8'h11, 160);
                repeat (139) @(negedge clk_200khz);
                do_event(8'h22, 160);
                total++; if (dropped_cnt !== 8'd0) begin bad++; $display("FAIL ovw_drop_2nd: got %0d required 0", dropped_cnt); end
                repeat (139) @(negedge clk_200khz);
                do_event(8'h33, 160);
                total++; if (dropped_cnt !== 8'd1) begin bad++; $display("FAIL ovw_drop_3rd: got %0d required 1", dropped_cnt); end
            end
            begin
                recv_frame("ovw_frame1", 8'h31, 8'h31);
                recv_frame("ovw_frame2", 8'h33, 8'h33);
            end
        join
        expect_quiet("ovw_no_22", 1000);
        total++; if (dropped_cnt !== 8'd1) begin bad++; $display("FAIL ovw_drop_final: got %0d required 1", dropped_cnt); end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        do_event(8'h3C, 160);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk_200khz);
            n++;
        end
        repeat (271) @(negedge clk_200khz);
        #2 rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1)           begin bad++; $display("FAIL rstmid_tx: got %b required 1", tx); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        total++; if (dropped_cnt !== 8'h00) begin bad++; $display("FAIL rstmid_dropped: got %0d required 0", dropped_cnt); end
        @(negedge clk_200khz);
        rst = 1'b0;
        expect_quiet("rstmid_quiet", 1000);
    endtask

    task automatic test_back_to_back_same;
        do_event(8'h5A, 160);
        recv_frame("same_first", 8'h35, 8'h41);
        repeat (20) @(negedge clk_200khz);
        do_event(8'h5A, 160);
`ifdef REPORT_ON_CHANGE_EN
        expect_quiet("same_suppressed", 1000);
`else
        recv_frame("same_second", 8'h35, 8'h41);
`endif
        repeat (20) @(negedge clk_200khz);
        do_event(8'hA5, 160);
        recv_frame("changed", 8'h41, 8'h35);
        total++; if (dropped_cnt !== 8'd0) begin bad++; $display("FAIL same_dropped: got %0d required 0", dropped_cnt); end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_ack_shape;
        test_overwrite;
        test_reset_mid_frame;
        test_back_to_back_same;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
